// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: state encoding, stream framing
// constants and a helper telling which states accept stream bytes.
package loader_pkg;

   localparam logic [2:0] ST_HDR_HI = 3'd0;
   localparam logic [2:0] ST_HDR_LO = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_CHK    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_ERROR  = 3'd5;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_HDR_HI = ST_HDR_HI,
      S_HDR_LO = ST_HDR_LO,
      S_DATA   = ST_DATA,
      S_CHK    = ST_CHK,
      S_DONE   = ST_DONE,
      S_ERROR  = ST_ERROR
   } state_t;

   function automatic logic is_loading(state_t s);
      return s inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CHK};
   endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from a byte stream.
// Ports: clk, reset (sync, active-low), clear, byte_en, byte_in -> word, word_valid.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt;
   logic [23:0] shift;

   // The 4th byte completes the word combinationally so the caller
   // can register the write strobe in the following cycle.
   assign word_valid = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
   assign word       = {shift, byte_in};

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         cnt   <= '0;
         shift <= '0;
      end else if (byte_en) begin
         cnt   <= cnt + 2'd1;
         shift <= {shift[15:0], byte_in};
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a byte stream (16-bit word
// count, then big-endian words) and holds the CPU until the load completes.
// Ports: clk, reset (sync, active-low), in_data/in_valid/in_ready stream,
// reload, imem_we/imem_addr/imem_data write port, cpu_run, load_err.
// Option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (state CHK).
module program_loader
   import loader_pkg::*;
#(
   parameter int                DEPTH     = 128,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   output logic              cpu_run,
   output logic              load_err
);

   localparam int IDX_W = $clog2(DEPTH + 1);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t         state_q, state_d;
   logic [7:0]     n_hi;
   logic [15:0]    n_words;
   logic [15:0]    hdr_n;
   logic [IDX_W-1:0] idx;
   logic           xfer;
   logic           pk_en;
   logic           pk_valid;
   logic [31:0]    pk_word;
   logic           last_word;
   logic           reload_ok;

   assign xfer      = in_valid && in_ready;
   assign hdr_n     = {n_hi, in_data};
   assign last_word = (16'(idx) + 16'd1) == n_words;
   assign reload_ok = reload && (state_q == S_DONE || state_q == S_ERROR);
   assign pk_en     = xfer && (state_q == S_DATA);
   assign imem_addr = BASE_ADDR + ADDR_W'({idx, 2'b00});

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] cksum;

   always_ff @(posedge clk) begin
      if (!reset || reload_ok) begin
         cksum <= '0;
      end else if (xfer && state_q != S_CHK) begin
         cksum <= cksum ^ in_data;
      end
   end
`endif

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (reload_ok),
      .byte_en    (pk_en),
      .byte_in    (in_data),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HDR_HI: if (xfer) state_d = S_HDR_LO;
         S_HDR_LO: begin
            if (xfer) begin
               if (hdr_n > 16'(DEPTH)) state_d = S_ERROR;
               else if (hdr_n == 16'd0) state_d = S_TAIL;
               else state_d = S_DATA;
            end
         end
         // Leave on the last byte so no stray byte is taken while the
         // final write strobe is still in flight.
         S_DATA: if (pk_valid && last_word) state_d = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) state_d = (in_data == cksum) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE:  if (reload) state_d = S_HDR_HI;
         S_ERROR: if (reload) state_d = S_HDR_HI;
         default: state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_HDR_HI;
         in_ready  <= 1'b0;
         imem_we   <= 1'b0;
         imem_data <= '0;
         cpu_run   <= 1'b0;
         load_err  <= 1'b0;
         idx       <= '0;
         n_hi      <= '0;
         n_words   <= '0;
      end else begin
         state_q  <= state_d;
         in_ready <= is_loading(state_d);
         cpu_run  <= (state_q == S_DONE) && (state_d == S_DONE);
         load_err <= (state_d == S_ERROR);
         imem_we  <= pk_valid;
         if (pk_valid) imem_data <= pk_word;
         if (reload_ok) idx <= '0;
         else if (imem_we) idx <= idx + 1'b1;
         if (xfer && state_q == S_HDR_HI) n_hi <= in_data;
         if (xfer && state_q == S_HDR_LO) n_words <= hdr_n;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and popped by an independent write monitor.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        reload;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        cpu_run;
   logic        load_err;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];

   always #5 clk = ~clk;

   program_loader dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .reload    (reload),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .cpu_run   (cpu_run),
      .load_err  (load_err)
   );

   // Write monitor
   always @(negedge clk) begin
      if (reset === 1'b1 && imem_we === 1'b1) begin
         wr_t e;
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_data);
         end else begin
            e = exp_q.pop_front();
            if (imem_addr !== e.addr || imem_data !== e.data) begin
               errors++;
               $display("FAIL write got %h@%h want %h@%h",
                        imem_data, imem_addr, e.data, e.addr);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, req);
      end
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got=0 want=1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      int w0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      reload   = 1'b0;

      // 1: reset state
      idle(3);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_imem_data", imem_data, 32'h0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      reset = 1'b1;
      idle(1);
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // 2: two-word load
      w0 = wr_count;
      expect_wr(32'h0, 32'h2001_0005);
      expect_wr(32'h4, 32'hAC01_0000);
      send_seq('{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                 8'hAC, 8'h01, 8'h00, 8'h00});
      idle(3);
      chk("t2_writes", 32'(wr_count - w0), 32'd2);
      chk("t2_cpu_run", 32'(cpu_run), 32'd1);
      chk("t2_in_ready", 32'(in_ready), 32'd0);
      chk("t2_load_err", 32'(load_err), 32'd0);
      pulse_reload();
      chk("t2_reload_run", 32'(cpu_run), 32'd0);
      chk("t2_reload_rdy", 32'(in_ready), 32'd1);

      // 3: same stream with a gap mid-word
      w0 = wr_count;
      expect_wr(32'h0, 32'h2001_0005);
      expect_wr(32'h4, 32'hAC01_0000);
      send_seq('{8'h00, 8'h02, 8'h20, 8'h01});
      idle(3);
      chk("t3_gap_no_run", 32'(cpu_run), 32'd0);
      send_seq('{8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00});
      idle(3);
      chk("t3_writes", 32'(wr_count - w0), 32'd2);
      chk("t3_cpu_run", 32'(cpu_run), 32'd1);

      // 4: oversize header
      pulse_reload();
      w0 = wr_count;
      send_seq('{8'h00, 8'h81});
      idle(3);
      chk("t4_load_err", 32'(load_err), 32'd1);
      chk("t4_cpu_run", 32'(cpu_run), 32'd0);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_writes", 32'(wr_count - w0), 32'd0);
      pulse_reload();
      chk("t4_err_clr", 32'(load_err), 32'd0);
      chk("t4_rdy_hdr", 32'(in_ready), 32'd1);

      // 5: reset mid-word discards the partial word
      w0 = wr_count;
      expect_wr(32'h0, 32'h1122_3344);
      send_seq('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB});
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(1);
      chk("t5_writes_pre", 32'(wr_count - w0), 32'd1);
      chk("t5_run_pre", 32'(cpu_run), 32'd0);
      expect_wr(32'h0, 32'hCAFE_BABE);
      send_seq('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE});
      idle(3);
      chk("t5_writes", 32'(wr_count - w0), 32'd2);
      chk("t5_cpu_run", 32'(cpu_run), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      // 6: checksum good then bad
      pulse_reload();
      w0 = wr_count;
      expect_wr(32'h0, 32'h1234_5678);
      send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09});
      idle(3);
      chk("t6_cpu_run", 32'(cpu_run), 32'd1);
      chk("t6_load_err", 32'(load_err), 32'd0);
      pulse_reload();
      expect_wr(32'h0, 32'h1234_5678);
      send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00});
      idle(3);
      chk("t6_bad_err", 32'(load_err), 32'd1);
      chk("t6_bad_run", 32'(cpu_run), 32'd0);
      chk("t6_writes", 32'(wr_count - w0), 32'd2);
`endif

      idle(2);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
